// File: rtl/alu_pkg.sv
// Opcodes, FSM encoding and opcode helpers shared by the ALU-sharing controller.
// Latency: n/a (declarations only). Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic alu_op_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SLT,
            OP_SLTU, OP_SUB, OP_XOR, OP_SRL, OP_SRA: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    function automatic logic alu_op_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
// Latency: purely combinational. Backpressure: en low forces gnt to zero.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    int   w_idx;
    logic w_found;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = (int'(ptr) + i) % NREQ;
            if (en && !w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_id     = IDW'(w_idx);
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU among NREQ requesters, one op at a time.
// Latency: legal op responds 2 cycles after grant, illegal op 1 cycle.
// Backpressure: response held until rsp_ready; no new grant until then.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*4-1:0]    req_op,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [3:0]           alu_ctrl,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    input  logic [WIDTH-1:0]     alu_y,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_err,
    input  logic                 rsp_ready
);

    localparam int SHW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_id;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;

    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_arb_en;
    logic             w_hs;
    logic [3:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_legal;

    // Reset wins over a same-cycle handshake, so no grant is offered under reset.
    assign w_arb_en = (r_state == ST_IDLE) && !reset;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (r_rr_ptr),
        .en     (w_arb_en),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign w_sel_op = req_op[int'(w_gnt_id)*4 +: 4];
    assign w_sel_a  = req_a[int'(w_gnt_id)*WIDTH +: WIDTH];
    assign w_sel_b  = req_b[int'(w_gnt_id)*WIDTH +: WIDTH];
    assign w_legal  = alu_op_legal(w_sel_op);

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_hs        = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = w_gnt;
                if (|w_gnt) begin
                    w_hs        = 1'b1;
                    w_state_nxt = w_legal ? ST_EXEC : ST_RESP;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_id     <= w_gnt_id;
                r_rr_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
                // Illegal ops never reach the ALU-facing registers.
                if (w_legal) begin
                    r_op <= w_sel_op;
                    r_a  <= w_sel_a;
                    r_b  <= w_sel_b;
                end else begin
                    r_result <= '0;
                    r_zero   <= 1'b0;
                    r_err    <= 1'b1;
                end
            end
            if (r_state == ST_EXEC) begin
                r_result <= alu_y;
                r_zero   <= alu_zero;
                r_err    <= 1'b0;
            end
        end
    end

    always_comb begin
        alu_ctrl = r_op;
        alu_a    = r_a;
        alu_b    = r_b;
        if (alu_op_shift(r_op)) begin
            alu_b = r_b & WIDTH'((1 << SHW) - 1);
        end
    end

    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;

endmodule
